soc_system_pio_in_irq: RTL and testbench

Parametrised Avalon-MM input PIO slave for the Nios soc_system. It replaces the fixed 1-bit read-only input ports (LT24 ADC IRQ, keys, switches) with one block of configurable width. The block synchronises the input bus and captures edges per bit. It raises a maskable interrupt to the Nios IRQ controller, so software no longer polls the ADC pen-IRQ line.

---
 rtl/soc_system_pio_pkg.sv | 20 ++
 rtl/soc_system_pio_sync.sv | 27 ++
 rtl/soc_system_pio_in_irq.sv | 126 ++++++++++++
 tb/tb_soc_system_pio_in_irq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system input PIO: Avalon register map,
// edge-select and interrupt-mode encodings.
package soc_system_pio_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH x SYNC_STAGES flop chain bringing asynchronous inputs into the clk domain.
module soc_system_pio_sync
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;

  // Stage 0 samples the pin; the last stage is the first usable value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_irq.sv
// Avalon-MM input PIO: synchronised input bus, per-bit edge capture (W1C),
// interrupt mask and a maskable level- or edge-sourced irq.
module soc_system_pio_in_irq
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 1,
  parameter int unsigned      IRQ_TYPE    = 1,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam int unsigned GUARD_MAX = SYNC_STAGES + 1;
  localparam int unsigned GUARD_W   = $clog2(GUARD_MAX + 1);

  logic [WIDTH-1:0]   w_sync_q;
  logic [WIDTH-1:0]   r_sync_d;
  logic [GUARD_W-1:0] r_guard;
  logic               w_guard_done;
  logic [WIDTH-1:0]   w_edge_raw;
  logic [WIDTH-1:0]   w_edge_hit;
  logic               w_wr;
  logic [WIDTH-1:0]   w_wdata;
  logic [WIDTH-1:0]   w_clr;
  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_edge;
  logic [DATA_W-1:0]  w_rd_mux;

  soc_system_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (in_port),
    .o_q     (w_sync_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_d <= '0;
    end else begin
      r_sync_d <= w_sync_q;
    end
  end

  // Hold off edge detection until the chain and delay flop hold real pin data.
  assign w_guard_done = (r_guard == GUARD_W'(GUARD_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_guard <= '0;
    end else if (!w_guard_done) begin
      r_guard <= r_guard + GUARD_W'(1);
    end
  end

  always_comb begin
    w_edge_raw = w_sync_q ^ r_sync_d;
    if (EDGE_TYPE == EDGE_RISE) begin
      w_edge_raw = w_sync_q & ~r_sync_d;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      w_edge_raw = ~w_sync_q & r_sync_d;
    end
  end

  assign w_edge_hit = w_guard_done ? w_edge_raw : '0;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_clr   = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

  if (WIDTH < DATA_W) begin : g_wdata_hi
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[DATA_W-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= RESET_MASK;
    end else if (w_wr && (address == ADDR_MASK)) begin
      r_mask <= w_wdata;
    end
  end

  // A new edge outranks a same-cycle W1C so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_edge_hit;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux = DATA_W'(w_sync_q);
      ADDR_MASK: w_rd_mux = DATA_W'(r_mask);
      ADDR_EDGE: w_rd_mux = DATA_W'(r_edge);
      default:   w_rd_mux = '0;
    endcase
  end

  // Read data refreshes every cycle so the slave has a fixed latency of one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = (IRQ_TYPE == IRQ_LEVEL) ? |(r_mask & w_sync_q) : |(r_mask & r_edge);

endmodule

// File: tb/tb_soc_system_pio_in_irq.sv
// Bench for soc_system_pio_in_irq: instance A is rising/edge-irq, instance B is
// falling/level-irq; register reads are scored against a queue of expectations.
module tb_soc_system_pio_in_irq;
  import soc_system_pio_pkg::*;

  typedef struct {
    logic [31:0] val;
    string       nm;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  a_addr, b_addr;
  logic        a_cs, b_cs, a_wn, b_wn;
  logic [31:0] a_wd, b_wd, a_rd, b_rd;
  logic [3:0]  a_in, b_in;
  logic        a_irq, b_irq;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_cmp = 0;
  int   n_bad = 0;

  soc_system_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE), .IRQ_TYPE(IRQ_EDGE), .RESET_MASK(4'h0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_addr), .chipselect(a_cs), .write_n(a_wn),
    .writedata(a_wd), .readdata(a_rd), .in_port(a_in), .irq(a_irq)
  );

  soc_system_pio_in_irq #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALL), .IRQ_TYPE(IRQ_LEVEL), .RESET_MASK(4'h2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(b_addr), .chipselect(b_cs), .write_n(b_wn),
    .writedata(b_wd), .readdata(b_rd), .in_port(b_in), .irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every read cycle pops the value queued when it was issued.
  always @(posedge clk) begin
    if (a_cs && a_wn && reset_n) begin
      #1;
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL a_unexpected_read: readdata=%h with no expectation queued", a_rd);
      end else begin
        ea = qa.pop_front();
        if (a_rd !== ea.val) begin
          n_bad++;
          $display("FAIL %s: readdata=%h expected %h", ea.nm, a_rd, ea.val);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (b_cs && b_wn && reset_n) begin
      #1;
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL b_unexpected_read: readdata=%h with no expectation queued", b_rd);
      end else begin
        eb = qb.pop_front();
        if (b_rd !== eb.val) begin
          n_bad++;
          $display("FAIL %s: readdata=%h expected %h", eb.nm, b_rd, eb.val);
        end
      end
    end
  end

  task automatic bus_idle();
    a_cs = 1'b0; a_wn = 1'b1; a_addr = 2'd0; a_wd = '0;
    b_cs = 1'b0; b_wn = 1'b1; b_addr = 2'd0; b_wd = '0;
  endtask

  // Called at a negedge; the access lands on the following posedge.
  task automatic bus_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
    if (sel == 0) begin
      a_addr = addr; a_wd = data; a_cs = 1'b1; a_wn = 1'b0;
    end else begin
      b_addr = addr; b_wd = data; b_cs = 1'b1; b_wn = 1'b0;
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int sel, input logic [1:0] addr, input logic [31:0] exp,
                          input string nm);
    exp_t e;
    e.val = exp;
    e.nm  = nm;
    if (sel == 0) begin
      qa.push_back(e);
      a_addr = addr; a_cs = 1'b1; a_wn = 1'b1;
    end else begin
      qb.push_back(e);
      b_addr = addr; b_cs = 1'b1; b_wn = 1'b1;
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 3;
    if (a_rd !== 32'h0) begin n_bad++; $display("FAIL rst_a_rd: readdata=%h expected 0", a_rd); end
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL rst_a_irq: irq=%b expected 0", a_irq); end
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL rst_b_irq: irq=%b expected 0", b_irq); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL rst_b_irq_fill: irq=%b expected 0", b_irq); end
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b1) begin n_bad++; $display("FAIL rst_b_irq_level: irq=%b expected 1", b_irq); end
    repeat (2) @(negedge clk);
    bus_read(0, ADDR_DATA, 32'h0000_000A, "rst_a_data");
    bus_read(0, ADDR_EDGE, 32'h0, "rst_a_edge_guard");
    bus_read(0, ADDR_MASK, 32'h0, "rst_a_mask");
    bus_read(1, ADDR_EDGE, 32'h0, "rst_b_edge_guard");
    bus_read(1, ADDR_MASK, 32'h2, "rst_b_mask");
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL rst_a_irq_guard: irq=%b expected 0", a_irq); end
  endtask

  task automatic test_regs();
    bus_write(0, ADDR_MASK, 32'hFFFF_FFF5);
    bus_read(0, ADDR_MASK, 32'h5, "regs_mask_trunc");
    bus_write(0, ADDR_RSVD, 32'hF);
    bus_read(0, ADDR_RSVD, 32'h0, "regs_reserved");
    bus_write(0, ADDR_DATA, 32'h5);
    bus_read(0, ADDR_DATA, 32'hA, "regs_data_ro");
    bus_write(0, ADDR_MASK, 32'h1);
  endtask

  task automatic test_rise();
    a_in[0] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_irq !== (i == 3)) begin
        n_bad++;
        $display("FAIL rise_irq_clk%0d: irq=%b expected %b", i, a_irq, (i == 3));
      end
    end
    bus_read(0, ADDR_EDGE, 32'h1, "rise_edge");
    a_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_EDGE, 32'h1, "rise_fall_ignored");
  endtask

  task automatic test_w1c();
    a_in[2] = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_EDGE, 32'h5, "w1c_pre");
    bus_write(0, ADDR_EDGE, 32'h4);
    bus_read(0, ADDR_EDGE, 32'h1, "w1c_post");
    n_cmp++;
    if (a_irq !== 1'b1) begin n_bad++; $display("FAIL w1c_irq_held: irq=%b expected 1", a_irq); end
    bus_write(0, ADDR_MASK, 32'h0);
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL w1c_mask_drop: irq=%b expected 0", a_irq); end
    bus_read(0, ADDR_EDGE, 32'h1, "w1c_edge_kept");
  endtask

  task automatic test_simultaneous();
    bus_write(0, ADDR_MASK, 32'h2);
    a_in[1] = 1'b0;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_EDGE, 32'h1, "sim_pre");
    a_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(0, ADDR_EDGE, 32'h2);
    n_cmp++;
    if (a_irq !== 1'b1) begin n_bad++; $display("FAIL sim_irq: irq=%b expected 1", a_irq); end
    bus_read(0, ADDR_EDGE, 32'h3, "sim_set_wins");
    bus_write(0, ADDR_EDGE, 32'h2);
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL sim_clear_irq: irq=%b expected 0", a_irq); end
    bus_read(0, ADDR_EDGE, 32'h1, "sim_cleared");
  endtask

  task automatic test_level();
    bus_write(1, ADDR_DATA, 32'h5);
    bus_read(1, ADDR_DATA, 32'hA, "lvl_data_ro");
    b_in[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b1) begin n_bad++; $display("FAIL lvl_fall_d1: irq=%b expected 1", b_irq); end
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL lvl_fall_d2: irq=%b expected 0", b_irq); end
    @(negedge clk);
    bus_read(1, ADDR_EDGE, 32'h2, "lvl_edge_fall");
    b_in[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL lvl_rise_d1: irq=%b expected 0", b_irq); end
    @(negedge clk);
    n_cmp++;
    if (b_irq !== 1'b1) begin n_bad++; $display("FAIL lvl_rise_d2: irq=%b expected 1", b_irq); end
    @(negedge clk);
    bus_read(1, ADDR_EDGE, 32'h2, "lvl_rise_ignored");
    bus_write(1, ADDR_EDGE, 32'h2);
    bus_read(1, ADDR_EDGE, 32'h0, "lvl_w1c");
    bus_write(1, ADDR_MASK, 32'hF);
    n_cmp++;
    if (b_irq !== 1'b1) begin n_bad++; $display("FAIL lvl_irq_mask_f: irq=%b expected 1", b_irq); end
  endtask

  task automatic test_reset_mid();
    a_in = 4'b0000;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_EDGE, 32'h1, "mid_fall_only");
    a_in = 4'b1111;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_EDGE, 32'hF, "mid_all_set");
    bus_write(0, ADDR_MASK, 32'hF);
    bus_read(0, ADDR_DATA, 32'hF, "mid_data");
    n_cmp++;
    if (a_irq !== 1'b1) begin n_bad++; $display("FAIL mid_irq_pre: irq=%b expected 1", a_irq); end
    reset_n = 1'b0;
    #1;
    n_cmp += 3;
    if (a_rd !== 32'h0) begin n_bad++; $display("FAIL mid_a_rd: readdata=%h expected 0", a_rd); end
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL mid_a_irq: irq=%b expected 0", a_irq); end
    if (b_irq !== 1'b0) begin n_bad++; $display("FAIL mid_b_irq: irq=%b expected 0", b_irq); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, ADDR_MASK, 32'h0, "mid_a_mask_reset");
    bus_read(0, ADDR_EDGE, 32'h0, "mid_a_guard_rearm");
    bus_read(1, ADDR_MASK, 32'h2, "mid_b_mask_reset");
    n_cmp++;
    if (a_irq !== 1'b0) begin n_bad++; $display("FAIL mid_a_irq_post: irq=%b expected 0", a_irq); end
  endtask

  initial begin
    reset_n = 1'b1;
    bus_idle();
    a_in = 4'b1010;
    b_in = 4'b1010;
    #1 reset_n = 1'b0;
    test_reset();
    test_regs();
    test_rise();
    test_w1c();
    test_simultaneous();
    test_level();
    test_reset_mid();
    @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: pending a=%0d b=%0d expected 0", qa.size(), qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
